// File: rtl/lcd_pkg.sv
// Shared types, init ROM and timing defaults for the HD44780 write engine.
// Timing values are in clk cycles; defaults assume a 50 MHz clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int DEF_T_PWRUP_CYC = 750000;
  localparam int DEF_T_SETUP_CYC = 4;
  localparam int DEF_T_EN_CYC    = 25;
  localparam int DEF_T_HOLD_CYC  = 4;
  localparam int DEF_T_EXEC_CYC  = 2500;
  localparam int DEF_T_SLOW_CYC  = 82000;

  // Function set 8-bit/2-line x3, display on, clear, entry mode increment.
  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx == 3'(i)) b = INIT_ROM[i];
    end
    return b;
  endfunction

  // Clear display (01) and return home (02/03) need the long execution time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b[7:1] == 7'b0000001) || (b == 8'h01));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter: holds at zero, done_o flags zero.
// A load of N-1 on state entry therefore yields exactly N cycles in that state.
module lcd_timer #(
  parameter int              W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= RST_VAL;
    end else if (load_i) begin
      count_reg <= value_i;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done_o = (count_reg == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write engine: power-up wait, fixed init sequence,
// then one byte per valid/ready handshake with setup/EN/hold/exec timing.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = DEF_T_PWRUP_CYC,
  parameter int T_SETUP_CYC = DEF_T_SETUP_CYC,
  parameter int T_EN_CYC    = DEF_T_EN_CYC,
  parameter int T_HOLD_CYC  = DEF_T_HOLD_CYC,
  parameter int T_EXEC_CYC  = DEF_T_EXEC_CYC,
  parameter int T_SLOW_CYC  = DEF_T_SLOW_CYC
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  localparam int T_MAX = (T_PWRUP_CYC > T_SLOW_CYC) ? T_PWRUP_CYC : T_SLOW_CYC;
  localparam int TW    = $clog2(T_MAX + 1);

  typedef logic [TW-1:0] tval_t;

  localparam tval_t LD_PWRUP = tval_t'(T_PWRUP_CYC - 1);
  localparam tval_t LD_SETUP = tval_t'(T_SETUP_CYC - 1);
  localparam tval_t LD_EN    = tval_t'(T_EN_CYC - 1);
  localparam tval_t LD_HOLD  = tval_t'(T_HOLD_CYC - 1);
  localparam tval_t LD_EXEC  = tval_t'(T_EXEC_CYC - 1);
  localparam tval_t LD_SLOW  = tval_t'(T_SLOW_CYC - 1);

  lcd_state_e state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic       init_done_reg, init_done_next;
  logic       ready_reg, ready_next;
  logic       en_reg, en_next;
  logic       rs_reg, rs_next;
  logic [7:0] data_reg, data_next;
  logic       on_reg;

  logic  tmr_load;
  tval_t tmr_value;
  logic  tmr_done;

  lcd_timer #(
    .W       (TW),
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  // State and registered pin/handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= PWRUP;
      idx_reg       <= '0;
      init_done_reg <= 1'b0;
      ready_reg     <= 1'b0;
      en_reg        <= 1'b0;
      rs_reg        <= 1'b0;
      data_reg      <= '0;
      on_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      init_done_reg <= init_done_next;
      ready_reg     <= ready_next;
      en_reg        <= en_next;
      rs_reg        <= rs_next;
      data_reg      <= data_next;
      on_reg        <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PWRUP:     if (tmr_done) state_next = INIT_LOAD;
      INIT_LOAD: state_next = SETUP;
      IDLE:      if (req_valid_i && ready_reg) state_next = SETUP;
      SETUP:     if (tmr_done) state_next = PULSE;
      PULSE:     if (tmr_done) state_next = HOLD;
      HOLD:      if (tmr_done) state_next = EXEC;
      EXEC: begin
        if (tmr_done) begin
          state_next = (!init_done_reg && (idx_reg != INIT_LAST)) ? INIT_LOAD : IDLE;
        end
      end
      default:   state_next = PWRUP;
    endcase
  end

  // Outputs are computed from the state being entered so the pins line up
  // with the state boundaries after the clock edge.
  always_comb begin
    tmr_load = (state_next != state_reg);
    case (state_next)
      PWRUP:   tmr_value = LD_PWRUP;
      SETUP:   tmr_value = LD_SETUP;
      PULSE:   tmr_value = LD_EN;
      HOLD:    tmr_value = LD_HOLD;
      EXEC:    tmr_value = is_slow_cmd(rs_reg, data_reg) ? LD_SLOW : LD_EXEC;
      default: tmr_value = '0;
    endcase

    en_next    = (state_next == PULSE);
    ready_next = (state_next == IDLE);

    rs_next   = rs_reg;
    data_next = data_reg;
    if (state_reg == INIT_LOAD) begin
      rs_next   = 1'b0;
      data_next = init_rom(idx_reg);
    end else if (state_reg == IDLE && state_next == SETUP) begin
      rs_next   = req_rs_i;
      data_next = req_data_i;
    end

    idx_next       = idx_reg;
    init_done_next = init_done_reg;
    if (state_reg == EXEC && tmr_done && !init_done_reg) begin
      if (idx_reg != INIT_LAST) begin
        idx_next = idx_reg + 3'd1;
      end else begin
        init_done_next = 1'b1;
      end
    end
  end

  assign req_ready_o = ready_reg;
  assign busy_o      = ~ready_reg;
  assign init_done_o = init_done_reg;
  assign lcd_data_o  = data_reg;
  assign lcd_rs_o    = rs_reg;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_reg;
  assign lcd_on_o    = on_reg;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected LCD writes are queued at issue
// time and a negedge monitor checks each EN pulse, its timing and the exec gap.
module tb_lcd_hd44780_ctrl;

  localparam int P_PWRUP = 10;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 5;
  localparam int P_SLOW  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_hd44780_ctrl #(
    .T_PWRUP_CYC (P_PWRUP),
    .T_SETUP_CYC (P_SETUP),
    .T_EN_CYC    (P_EN),
    .T_HOLD_CYC  (P_HOLD),
    .T_EXEC_CYC  (P_EXEC),
    .T_SLOW_CYC  (P_SLOW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rs_i    (req_rs),
    .req_data_i  (req_data),
    .init_done_o (init_done),
    .busy_o      (busy),
    .lcd_data_o  (lcd_data),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_en_o    (lcd_en),
    .lcd_on_o    (lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         writes_seen = 0;
  logic       mon_busy = 1'b0;
  logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rules: clear (01) and home (02/03) with RS=0 take the slow exec time.
  function automatic bit slow_rule(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  // gap = idle EN-low cycles after the pulse until ready (or, inside the init
  // chain, until the next pulse, which adds one load cycle plus setup).
  function automatic void push_write(input logic rs, input logic [7:0] d, input bit chained);
    exp_t e;
    e.rs   = rs;
    e.data = d;
    e.gap  = P_HOLD + (slow_rule(rs, d) ? P_SLOW : P_EXEC) + (chained ? 1 + P_SETUP : 0);
    exp_q.push_back(e);
  endfunction

  function automatic void push_init();
    for (int i = 0; i < 6; i++) push_write(1'b0, init_bytes[i], i < 5);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic send(input logic rs, input logic [7:0] d);
    int n = 0;
    push_write(rs, d, 1'b0);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 3000), 1);
    @(negedge clk);
    check("ready_drop", req_ready, 0);
  endtask

  task automatic drop();
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 5000), 1);
  endtask

  // Monitor state
  logic       prev_en = 1'b0, prev_done = 1'b0, in_pulse = 1'b0, in_gap = 1'b0;
  int         width = 0, gap_cnt = 0, hold_left = 0, cur_gap = 0;
  logic [8:0] h1 = '0, h2 = '0, cap = '0, now_v = '0;
  exp_t       e_cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0; prev_done = 1'b0; in_pulse = 1'b0; in_gap = 1'b0;
        h1 = '0; h2 = '0; mon_busy = 1'b0;
        continue;
      end
      now_v = {lcd_rs, lcd_data};
      check("rw_low", lcd_rw, 0);
      check("busy_inverse", busy, !req_ready);
      check("ready_gated_by_init", req_ready & ~init_done, 0);
      if (init_done && !prev_done) check("done_with_ready", req_ready, 1);

      if (lcd_en && !prev_en) begin
        if (in_gap) check("exec_gap", gap_cnt, cur_gap);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rs=%0d data=%02h, required no write", lcd_rs, lcd_data);
          cur_gap = 0;
        end else begin
          e_cur = exp_q.pop_front();
          check("write_rs", lcd_rs, e_cur.rs);
          check("write_data", lcd_data, e_cur.data);
          cur_gap = e_cur.gap;
        end
        check("setup_m1", h1, now_v);
        check("setup_m2", h2, now_v);
        writes_seen++;
        $display("write %0d: rs=%0d data=%02h t=%0t", writes_seen, lcd_rs, lcd_data, $time);
        cap = now_v; width = 1; in_pulse = 1'b1; in_gap = 1'b0;
      end else if (lcd_en && prev_en) begin
        width++;
        check("pulse_stable", now_v, cap);
      end else if (!lcd_en && prev_en) begin
        check("en_width", width, P_EN);
        check("hold_stable", now_v, cap);
        in_pulse = 1'b0; in_gap = 1'b1; gap_cnt = 1; hold_left = P_HOLD - 1;
      end else if (in_gap) begin
        if (req_ready) begin
          check("exec_gap", gap_cnt, cur_gap);
          in_gap = 1'b0;
        end else begin
          gap_cnt++;
          if (hold_left > 0) begin
            check("hold_stable", now_v, cap);
            hold_left--;
          end
        end
      end
      mon_busy  = in_pulse | in_gap;
      h2        = h1;
      h1        = now_v;
      prev_en   = lcd_en;
      prev_done = init_done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic       rs;
    logic [7:0] d;

    // Reset state and power-up, with a request already pending during init.
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_on", lcd_on, 0);
    check("rst_done", init_done, 0);
    check("rst_data", {lcd_rs, lcd_data}, 0);
    push_init();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("on_after_release", lcd_on, 1);
    send(1'b1, 8'h55);
    drop();
    wait_quiet();

    // Single data write with EN latency from the accepting edge.
    send(1'b1, 8'h41);
    drop();
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("en_latency", n, P_SETUP);
    wait_quiet();

    // Valid held across busy for two back-to-back writes.
    send(1'b1, 8'h42);
    send(1'b1, 8'h43);
    drop();
    wait_quiet();

    // Slow home command vs. data byte 01 that must not be slow.
    send(1'b0, 8'h02);
    drop();
    send(1'b1, 8'h01);
    drop();
    wait_quiet();

    // Randomized writes with random idle gaps.
    for (int i = 0; i < 14; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      send(rs, d);
      if ($urandom_range(0, 1) == 1) begin
        drop();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop();
    wait_quiet();

    // Reset in the middle of an EN pulse, then full re-init.
    send(1'b1, 8'h77);
    drop();
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("en_seen_before_reset", lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_en_drop", lcd_en, 0);
    check("async_ready", req_ready, 0);
    check("async_busy", busy, 1);
    check("async_on", lcd_on, 0);
    check("async_done", init_done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("on_after_rerelease", lcd_on, 1);
    check("not_done_after_reset", init_done, 0);
    send(1'b1, 8'h5A);
    drop();
    wait_quiet();

    check("queue_empty", exp_q.size(), 0);
    check("write_count", writes_seen, 6 + 1 + 1 + 2 + 2 + 14 + 1 + 6 + 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
